// File: rtl/core_pkg.sv
// Shared RV32I core types: ALU op encodings, default widths and the ID/EX register layout.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_OP_W   = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd9;

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       op1;
    logic [XLEN-1:0]       op2;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  alu_src;
    logic [ALU_OP_W-1:0]   alu_op;
  } id_ex_t;

endpackage

// File: rtl/hazard_unit.sv
// Load-use detector: stalls decode when the load in EX feeds a source of the decoded instruction.
// Purely combinational; a taken flush suppresses the stall since the younger instruction dies anyway.
module hazard_unit
  import core_pkg::*;
#(
  parameter int ADDRESS_WIDTH = REG_ADDR_W
) (
  input  logic                     id_valid_i,
  input  logic [ADDRESS_WIDTH-1:0] id_rs1_i,
  input  logic [ADDRESS_WIDTH-1:0] id_rs2_i,
  input  logic                     ex_valid_i,
  input  logic                     ex_mem_read_i,
  input  logic [ADDRESS_WIDTH-1:0] ex_rd_i,
  input  logic                     ex_flush_i,
  output logic                     id_stall_o
);

  logic rd_match;

  assign rd_match   = (ex_rd_i != '0) && ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
  assign id_stall_o = id_valid_i && ex_valid_i && ex_mem_read_i && rd_match && !ex_flush_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with same-cycle writeback bypass; 1-cycle latency.
// Inserts a bubble on branch flush (highest priority) or load-use stall.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int DATA_WIDTH    = XLEN,
  parameter int ADDRESS_WIDTH = REG_ADDR_W,
  parameter int ALUOP_WIDTH   = ALU_OP_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic [ADDRESS_WIDTH-1:0] id_rs1,
  input  logic [ADDRESS_WIDTH-1:0] id_rs2,
  input  logic [ADDRESS_WIDTH-1:0] id_rd,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     id_alu_src,
  input  logic [ALUOP_WIDTH-1:0]   id_alu_op,
  input  logic [DATA_WIDTH-1:0]    rf_read1,
  input  logic [DATA_WIDTH-1:0]    rf_read2,
  input  logic                     wb_reg_write,
  input  logic [ADDRESS_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  input  logic                     ex_flush,
  output logic                     id_stall,
  output logic                     ex_valid,
  output logic [DATA_WIDTH-1:0]    ex_pc,
  output logic [DATA_WIDTH-1:0]    ex_imm,
  output logic [DATA_WIDTH-1:0]    ex_op1,
  output logic [DATA_WIDTH-1:0]    ex_op2,
  output logic [ADDRESS_WIDTH-1:0] ex_rs1,
  output logic [ADDRESS_WIDTH-1:0] ex_rs2,
  output logic [ADDRESS_WIDTH-1:0] ex_rd,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic                     ex_alu_src,
  output logic [ALUOP_WIDTH-1:0]   ex_alu_op
);

  id_ex_t                ex_d, ex_q;
  logic [DATA_WIDTH-1:0] op1, op2;
  logic                  bypass1, bypass2;

  // Regfile reads do not see a write landing this cycle, so forward it here.
  assign bypass1 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1);
  assign bypass2 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2);
  assign op1     = bypass1 ? wb_data : rf_read1;
  assign op2     = bypass2 ? wb_data : rf_read2;

  hazard_unit #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_hazard (
    .id_valid_i    (id_valid),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .ex_valid_i    (ex_q.valid),
    .ex_mem_read_i (ex_q.mem_read),
    .ex_rd_i       (ex_q.rd),
    .ex_flush_i    (ex_flush),
    .id_stall_o    (id_stall)
  );

  always_comb begin
    ex_d = ex_q;
    if (ex_flush || id_stall) begin
      // Bubble: only the side-effect controls matter; data fields just hold.
      ex_d.valid     = 1'b0;
      ex_d.reg_write = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.mem_write = 1'b0;
    end else begin
      ex_d.valid     = id_valid;
      ex_d.pc        = id_pc;
      ex_d.imm       = id_imm;
      ex_d.op1       = op1;
      ex_d.op2       = op2;
      ex_d.rs1       = id_rs1;
      ex_d.rs2       = id_rs2;
      ex_d.rd        = id_rd;
      ex_d.reg_write = id_reg_write && id_valid;
      ex_d.mem_read  = id_mem_read && id_valid;
      ex_d.mem_write = id_mem_write && id_valid;
      ex_d.alu_src   = id_alu_src;
      ex_d.alu_op    = id_alu_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_imm       = ex_q.imm;
  assign ex_op1       = ex_q.op1;
  assign ex_op2       = ex_q.op2;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_alu_src   = ex_q.alu_src;
  assign ex_alu_op    = ex_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, pass-through, bypass, load-use, flush priority, invalid slot.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_reg_write, id_mem_read, id_mem_write, id_alu_src;
  logic [3:0]  id_alu_op;
  logic [31:0] rf_read1, rf_read2;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_flush;
  logic        id_stall, ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_op1, ex_op2;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
  logic [3:0]  ex_alu_op;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_imm(id_imm), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .rf_read1(rf_read1), .rf_read2(rf_read2),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_flush(ex_flush), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; id_pc = 0; id_imm = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_alu_src = 0; id_alu_op = 0;
    rf_read1 = 0; rf_read2 = 0; wb_reg_write = 0; wb_rd = 0; wb_data = 0; ex_flush = 0;
  endtask

  task automatic issue_load(input logic [4:0] rd);
    set_idle();
    id_valid = 1; id_pc = 32'h200; id_rd = rd; id_mem_read = 1; id_reg_write = 1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1; set_idle();
    tick(); tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
    n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", id_stall); end
    rst = 0;
    // Load in EX with a dependent decode, then reset mid-cycle.
    issue_load(5'd5);
    set_idle(); id_valid = 1; id_rs1 = 5'd5; #1;
    n_cmp++; if (id_stall !== 1'b1) begin n_err++; $display("FAIL prereset_stall: got %b want 1", id_stall); end
    n_cmp++; if (ex_pc !== 32'h200) begin n_err++; $display("FAIL prereset_pc: got %h want 00000200", ex_pc); end
    rst = 1; #1;
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL async_valid: got %b want 0", ex_valid); end
    n_cmp++; if (ex_pc !== 32'h0) begin n_err++; $display("FAIL async_pc: got %h want 0", ex_pc); end
    n_cmp++; if ({ex_reg_write, ex_mem_read, ex_rd} !== 7'b0) begin
      n_err++; $display("FAIL async_ctrl: got %b want 0", {ex_reg_write, ex_mem_read, ex_rd}); end
    n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL async_stall: got %b want 0", id_stall); end
    tick();
    rst = 0; set_idle();
    tick();
  endtask

  task automatic test_pass_through();
    set_idle();
    id_valid = 1; id_pc = 32'h100; id_rs1 = 5'd3; id_rs2 = 5'd4; id_rd = 5'd7;
    id_imm = 32'hFFFF_FFF0; id_reg_write = 1; id_alu_src = 1; id_alu_op = 4'd2;
    rf_read1 = 32'h11; rf_read2 = 32'h22;
    tick();
    n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL pt_valid: got %b want 1", ex_valid); end
    n_cmp++; if (ex_op1 !== 32'h11) begin n_err++; $display("FAIL pt_op1: got %h want 00000011", ex_op1); end
    n_cmp++; if (ex_op2 !== 32'h22) begin n_err++; $display("FAIL pt_op2: got %h want 00000022", ex_op2); end
    n_cmp++; if (ex_pc !== 32'h100) begin n_err++; $display("FAIL pt_pc: got %h want 00000100", ex_pc); end
    n_cmp++; if (ex_imm !== 32'hFFFF_FFF0) begin n_err++; $display("FAIL pt_imm: got %h want fffffff0", ex_imm); end
    n_cmp++; if ({ex_rs1, ex_rs2, ex_rd} !== {5'd3, 5'd4, 5'd7}) begin
      n_err++; $display("FAIL pt_idx: got %0d/%0d/%0d want 3/4/7", ex_rs1, ex_rs2, ex_rd); end
    n_cmp++; if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_alu_op} !== 8'b1001_0010) begin
      n_err++; $display("FAIL pt_ctrl: got %b want 10010010",
                        {ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_alu_op}); end
  endtask

  task automatic test_bypass();
    set_idle();
    id_valid = 1; id_rs1 = 5'd3; id_rs2 = 5'd4; rf_read1 = 32'h11; rf_read2 = 32'h22;
    wb_reg_write = 1; wb_rd = 5'd3; wb_data = 32'hDEAD;
    tick();
    n_cmp++; if (ex_op1 !== 32'hDEAD) begin n_err++; $display("FAIL byp_op1: got %h want 0000dead", ex_op1); end
    n_cmp++; if (ex_op2 !== 32'h22) begin n_err++; $display("FAIL byp_op2_untouched: got %h want 00000022", ex_op2); end
    wb_rd = 5'd0; id_rs1 = 5'd0;
    tick();
    n_cmp++; if (ex_op1 !== 32'h11) begin n_err++; $display("FAIL byp_x0: got %h want 00000011", ex_op1); end
    wb_rd = 5'd3; id_rs1 = 5'd3; wb_reg_write = 0;
    tick();
    n_cmp++; if (ex_op1 !== 32'h11) begin n_err++; $display("FAIL byp_no_we: got %h want 00000011", ex_op1); end
    wb_reg_write = 1; wb_rd = 5'd9; id_rs1 = 5'd9; id_rs2 = 5'd9; wb_data = 32'hBEEF_0001;
    tick();
    n_cmp++; if (ex_op1 !== 32'hBEEF_0001) begin n_err++; $display("FAIL byp_both_op1: got %h want beef0001", ex_op1); end
    n_cmp++; if (ex_op2 !== 32'hBEEF_0001) begin n_err++; $display("FAIL byp_both_op2: got %h want beef0001", ex_op2); end
  endtask

  task automatic test_load_use();
    issue_load(5'd5);
    set_idle();
    id_valid = 1; id_pc = 32'h204; id_rs1 = 5'd1; id_rs2 = 5'd5; id_rd = 5'd6; id_reg_write = 1;
    rf_read2 = 32'h55; #1;
    n_cmp++; if (id_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %b want 1", id_stall); end
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble_valid: got %b want 0", ex_valid); end
    n_cmp++; if ({ex_reg_write, ex_mem_read} !== 2'b00) begin
      n_err++; $display("FAIL lu_bubble_ctrl: got %b want 00", {ex_reg_write, ex_mem_read}); end
    n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_clear: got %b want 0", id_stall); end
    wb_reg_write = 1; wb_rd = 5'd5; wb_data = 32'hCAFE;
    tick();
    n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL lu_retry_valid: got %b want 1", ex_valid); end
    n_cmp++; if (ex_op2 !== 32'hCAFE) begin n_err++; $display("FAIL lu_retry_op2: got %h want 0000cafe", ex_op2); end
    n_cmp++; if (ex_pc !== 32'h204) begin n_err++; $display("FAIL lu_retry_pc: got %h want 00000204", ex_pc); end
    // Loads to x0 and non-load producers never stall.
    issue_load(5'd0);
    set_idle(); id_valid = 1; id_rs1 = 5'd0; #1;
    n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL lu_x0: got %b want 0", id_stall); end
    set_idle(); id_valid = 1; id_rd = 5'd5; id_reg_write = 1;
    tick();
    id_rs1 = 5'd5; #1;
    n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL lu_nonload: got %b want 0", id_stall); end
  endtask

  task automatic test_flush_priority();
    issue_load(5'd5);
    set_idle();
    id_valid = 1; id_rs1 = 5'd5; id_mem_write = 1; id_reg_write = 1; ex_flush = 1; #1;
    n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL fl_stall: got %b want 0", id_stall); end
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL fl_valid: got %b want 0", ex_valid); end
    n_cmp++; if ({ex_mem_write, ex_reg_write, ex_mem_read} !== 3'b000) begin
      n_err++; $display("FAIL fl_ctrl: got %b want 000", {ex_mem_write, ex_reg_write, ex_mem_read}); end
    ex_flush = 0;
  endtask

  task automatic test_invalid_slot();
    set_idle();
    id_valid = 0; id_pc = 32'h300; id_reg_write = 1; id_mem_read = 1; id_mem_write = 1;
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL inv_valid: got %b want 0", ex_valid); end
    n_cmp++; if ({ex_reg_write, ex_mem_read, ex_mem_write} !== 3'b000) begin
      n_err++; $display("FAIL inv_ctrl: got %b want 000", {ex_reg_write, ex_mem_read, ex_mem_write}); end
    n_cmp++; if (ex_pc !== 32'h300) begin n_err++; $display("FAIL inv_pc: got %h want 00000300", ex_pc); end
  endtask

  task automatic test_back_to_back();
    set_idle();
    for (int i = 1; i <= 4; i++) begin
      id_valid = 1; id_pc = 32'h400 + 32'(4 * i); id_rd = 5'(i); id_reg_write = 1;
      rf_read1 = 32'(i * 16);
      tick();
      n_cmp++; if (ex_pc !== 32'h400 + 32'(4 * i) || ex_op1 !== 32'(i * 16) || ex_valid !== 1'b1) begin
        n_err++; $display("FAIL b2b_%0d: got pc=%h op1=%h v=%b want pc=%h op1=%h v=1",
                          i, ex_pc, ex_op1, ex_valid, 32'h400 + 32'(4 * i), 32'(i * 16)); end
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_bypass();
    test_load_use();
    test_flush_priority();
    test_invalid_slot();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
